uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter CLKS_PER_TIMEOUT, default 25000, inter-byte timeout in clocks (1 ms at 25 MHz).
REQ-002 Port CLK  input  1  system clock, 25 MHz, shared with the UART receiver and the VGA timing generator.
REQ-003 Port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port i_RX_DV  input  1  one-cycle strobe from the UART receiver: byte valid.
REQ-005 Port i_RX_Byte  input  8  received byte, sampled only when i_RX_DV=1.
REQ-006 Port o_Pattern  output  4  VGA test-pattern select.
REQ-007 Port o_Red  output  3  solid-colour red level.
REQ-008 Port o_Green  output  3  solid-colour green level.
REQ-009 Port o_Blue  output  3  solid-colour blue level.
REQ-010 Port o_Cmd_Valid  output  1  one-cycle pulse: a command was applied.
REQ-011 Port o_Err  output  1  one-cycle pulse: a packet was rejected.
REQ-012 Port o_Busy  output  1  high while a packet is partially received (state not IDLE).

Function
REQ-013 The packet format SHALL be SYNC (0xA5), CMD, DATA, then CHK only when CHECKSUM_EN is defined.
REQ-014 The FSM SHALL have states IDLE, GET_CMD, GET_DATA, GET_CHK, APPLY.
REQ-015 In IDLE, 0xA5 -> GET_CMD; any other byte is ignored with no o_Err.
REQ-016 GET_CMD SHALL latch CMD and go to GET_DATA; 0xA5 here is latched as an ordinary CMD, with no resync.
REQ-017 GET_DATA SHALL latch DATA and go to GET_CHK when CHECKSUM_EN is defined, else to APPLY.
REQ-018 APPLY SHALL last one cycle, update outputs, pulse o_Cmd_Valid or o_Err, then return to IDLE.
REQ-019 Output registers and o_Cmd_Valid SHALL change on the clock edge following the cycle in which APPLY is active.
  - Latency: 2 clocks after the final byte's i_RX_DV cycle.
REQ-020 Command decode SHALL be as follows:
  - 0x01: o_Pattern <= DATA[3:0]
  - 0x02: o_Red <= DATA[2:0]
  - 0x03: o_Green <= DATA[2:0]
  - 0x04: o_Blue <= DATA[2:0]
  - 0x05: {o_Red,o_Green,o_Blue} <= {DATA[7:5],DATA[4:2],DATA[1:0],1'b0}
  - Unused DATA bits are ignored.
REQ-021 Any other CMD SHALL cause an o_Err pulse in APPLY, with no output change.
REQ-022 A 16-bit idle counter SHALL clear on every i_RX_DV and whenever state is IDLE, and increment otherwise.
REQ-023 When the counter reaches CLKS_PER_TIMEOUT-1 outside IDLE, the FSM SHALL go to IDLE, pulse o_Err, and discard the partial packet.
REQ-024 If i_RX_DV and the timeout coincide, the byte SHALL be processed and the timeout ignored.
REQ-025 o_Cmd_Valid and o_Err SHALL never be high in the same cycle.
REQ-026 i_RX_DV asserted during APPLY SHALL be ignored.

Reset
REQ-027 On RST_N low, the FSM SHALL go to IDLE immediately, independent of CLK.
REQ-028 On RST_N low, the counter and latched CMD/DATA SHALL clear.
REQ-029 Reset values: o_Pattern=0, o_Red=0, o_Green=0, o_Blue=0, o_Cmd_Valid=0, o_Err=0, o_Busy=0.
REQ-030 Reset asserted mid-packet SHALL discard the packet; the next packet after release SHALL decode normally.

Configuration
REQ-031 Macro UART_CMD_CHECKSUM_EN SHALL select checksum checking.
  - Defined: GET_CHK present; CHK must equal CMD xor DATA, else APPLY pulses o_Err with no update.
  - Undefined: GET_CHK and its comparator are absent; packets are 3 bytes.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, SYNC_BYTE=0xA5, command codes 0x01-0x05, and the default CLKS_PER_TIMEOUT.
REQ-033 The idle timer SHALL be a sub-module, uart_cmd_timeout, with clear, enable, and expired ports.

Verification
REQ-034 CHECKSUM_EN undefined: A5,01,07 -> o_Pattern=7 with one o_Cmd_Valid pulse 2 clocks after the last DV.
REQ-035 CHECKSUM_EN defined: A5,05,B6,B3 -> o_Red=5, o_Green=5, o_Blue=4.
  - Same packet with CHK=00 -> one o_Err pulse, colours unchanged.
REQ-036 Bytes 3C,A5,09,00 (no checksum) -> 3C ignored; CMD 09 -> o_Err, outputs unchanged, o_Busy back to 0.
REQ-037 A5,02, then no byte for CLKS_PER_TIMEOUT clocks -> o_Err at count 24999, IDLE.
  - Next A5,02,03 -> o_Red=3.
REQ-038 RST_N pulsed low between DATA and CHK -> all outputs 0 asynchronously.
  - A following full valid packet is applied correctly.
REQ-039 i_RX_DV with a byte on the exact timeout cycle -> byte accepted, no o_Err.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder:
// FSM state encoding, the sync byte, command codes and the default timeout.
// Optional macro UART_CMD_CHECKSUM_EN adds the GET_CHK state.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_APPLY    = 3'd3
`ifdef UART_CMD_CHECKSUM_EN
    , ST_GET_CHK = 3'd4
`endif
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_PATTERN = 8'h01;
  localparam logic [7:0] CMD_RED     = 8'h02;
  localparam logic [7:0] CMD_GREEN   = 8'h03;
  localparam logic [7:0] CMD_BLUE    = 8'h04;
  localparam logic [7:0] CMD_RGB     = 8'h05;

  // 1 ms at the 25 MHz system clock
  localparam int CLKS_PER_TIMEOUT_DEF = 25000;

  // True for the command codes the decoder knows how to apply
  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_PATTERN) || (c == CMD_RED) || (c == CMD_GREEN) ||
           (c == CMD_BLUE)    || (c == CMD_RGB);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_timeout.sv
// Inter-byte idle timer for the UART command decoder.
// 16-bit counter: clear wins over enable; o_Expired flags the last count.
module uart_cmd_timeout
  import uart_cmd_decoder_pkg::*;
#(
  parameter int CLKS_PER_TIMEOUT = CLKS_PER_TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  logic [15:0] r_Count;

  // Count idle clocks while enabled; any clear restarts from zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        r_Count <= '0;
    else if (i_Clear)  r_Count <= '0;
    else if (i_Enable) r_Count <= r_Count + 16'd1;
  end

  assign o_Expired = i_Enable && (r_Count == 16'(CLKS_PER_TIMEOUT - 1));

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses SYNC/CMD/DATA[/CHK] packets from a UART
// receiver and drives VGA test-pattern and solid-colour registers.
// Define UART_CMD_CHECKSUM_EN to require a CHK byte equal to CMD ^ DATA.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int CLKS_PER_TIMEOUT = CLKS_PER_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [3:0] o_Pattern,
  output logic [2:0] o_Red,
  output logic [2:0] o_Green,
  output logic [2:0] o_Blue,
  output logic       o_Cmd_Valid,
  output logic       o_Err,
  output logic       o_Busy
);

  state_t      r_State, w_Next;
  logic [7:0]  r_Cmd, r_Data;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  r_Chk;
`endif
  logic [3:0]  r_Pattern;
  logic [2:0]  r_Red, r_Green, r_Blue;
  logic        r_Cmd_Valid, r_Err;
  logic        w_Expired, w_Timeout, w_Apply_Ok, w_Apply_Err, w_Idle;

  assign w_Idle = (r_State == ST_IDLE);

  uart_cmd_timeout #(.CLKS_PER_TIMEOUT(CLKS_PER_TIMEOUT)) u_timeout (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_Clear  (i_RX_DV | w_Idle),
    .i_Enable (!w_Idle),
    .o_Expired(w_Expired)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout;
  // APPLY always completes on its own so it never times out.
  assign w_Timeout = w_Expired && !i_RX_DV && (r_State != ST_APPLY);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_State <= ST_IDLE;
    else        r_State <= w_Next;
  end

  // Next-state logic
  always_comb begin
    w_Next = r_State;
    case (r_State)
      ST_IDLE:     if (i_RX_DV && i_RX_Byte == SYNC_BYTE) w_Next = ST_GET_CMD;
      ST_GET_CMD:  if (i_RX_DV) w_Next = ST_GET_DATA;
                   else if (w_Timeout) w_Next = ST_IDLE;
`ifdef UART_CMD_CHECKSUM_EN
      ST_GET_DATA: if (i_RX_DV) w_Next = ST_GET_CHK;
                   else if (w_Timeout) w_Next = ST_IDLE;
      ST_GET_CHK:  if (i_RX_DV) w_Next = ST_APPLY;
                   else if (w_Timeout) w_Next = ST_IDLE;
`else
      ST_GET_DATA: if (i_RX_DV) w_Next = ST_APPLY;
                   else if (w_Timeout) w_Next = ST_IDLE;
`endif
      ST_APPLY:    w_Next = ST_IDLE;
      default:     w_Next = ST_IDLE;
    endcase
  end

  // Output decode: APPLY either accepts the packet or rejects it
  always_comb begin
    w_Apply_Ok  = 1'b0;
    w_Apply_Err = 1'b0;
    if (r_State == ST_APPLY) begin
`ifdef UART_CMD_CHECKSUM_EN
      if (cmd_known(r_Cmd) && (r_Chk == (r_Cmd ^ r_Data))) w_Apply_Ok = 1'b1;
`else
      if (cmd_known(r_Cmd)) w_Apply_Ok = 1'b1;
`endif
      else w_Apply_Err = 1'b1;
    end
  end

  // Latch packet fields as they arrive; 0xA5 in the CMD slot is just a CMD
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_Cmd  <= '0;
      r_Data <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      r_Chk  <= '0;
`endif
    end else if (i_RX_DV) begin
      if (r_State == ST_GET_CMD)  r_Cmd  <= i_RX_Byte;
      if (r_State == ST_GET_DATA) r_Data <= i_RX_Byte;
`ifdef UART_CMD_CHECKSUM_EN
      if (r_State == ST_GET_CHK)  r_Chk  <= i_RX_Byte;
`endif
    end
  end

  // Apply an accepted command and register the one-cycle status pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_Pattern   <= '0;
      r_Red       <= '0;
      r_Green     <= '0;
      r_Blue      <= '0;
      r_Cmd_Valid <= 1'b0;
      r_Err       <= 1'b0;
    end else begin
      r_Cmd_Valid <= w_Apply_Ok;
      r_Err       <= w_Apply_Err | w_Timeout;
      if (w_Apply_Ok) begin
        case (r_Cmd)
          CMD_PATTERN: r_Pattern <= r_Data[3:0];
          CMD_RED:     r_Red     <= r_Data[2:0];
          CMD_GREEN:   r_Green   <= r_Data[2:0];
          CMD_BLUE:    r_Blue    <= r_Data[2:0];
          CMD_RGB: begin
            r_Red   <= r_Data[7:5];
            r_Green <= r_Data[4:2];
            r_Blue  <= {r_Data[1:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Pattern   = r_Pattern;
  assign o_Red       = r_Red;
  assign o_Green     = r_Green;
  assign o_Blue      = r_Blue;
  assign o_Cmd_Valid = r_Cmd_Valid;
  assign o_Err       = r_Err;
  assign o_Busy      = !w_Idle;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of packets plus hand-written corner
// sequences; expected pulses are queued when driven and checked on arrival.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int TO = 25000;

  logic       CLK = 1'b0, RST_N = 1'b0, i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic [3:0] o_Pattern;
  logic [2:0] o_Red, o_Green, o_Blue;
  logic       o_Cmd_Valid, o_Err, o_Busy;

  uart_cmd_decoder #(.CLKS_PER_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Pattern(o_Pattern), .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue),
    .o_Cmd_Valid(o_Cmd_Valid), .o_Err(o_Err), .o_Busy(o_Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { logic is_err; logic [3:0] pat; logic [2:0] r, g, b; int at; } exp_t;
  typedef struct { logic [7:0] cmd, data; logic is_err; logic [3:0] pat; logic [2:0] r, g, b; } vec_t;

  exp_t sbq[$];
  exp_t e_m;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every status pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (RST_N && (o_Cmd_Valid || o_Err)) begin
      chk("pulse_exclusive", {31'd0, o_Cmd_Valid & o_Err}, 0);
      chk("pulse_expected", {31'd0, sbq.size() > 0}, 1);
      if (sbq.size() > 0) begin
        e_m = sbq.pop_front();
        chk("pulse_kind_err", {31'd0, o_Err}, {31'd0, e_m.is_err});
        chk("pulse_cycle", cyc, e_m.at);
        chk("pattern", {28'd0, o_Pattern}, {28'd0, e_m.pat});
        chk("red", {29'd0, o_Red}, {29'd0, e_m.r});
        chk("green", {29'd0, o_Green}, {29'd0, e_m.g});
        chk("blue", {29'd0, o_Blue}, {29'd0, e_m.b});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int dc);
    @(posedge CLK); #1;
    dc = cyc; i_RX_DV = 1'b1; i_RX_Byte = b;
    @(posedge CLK); #1;
    i_RX_DV = 1'b0;
  endtask

  // Full packet with a correct checksum when checksums are enabled
  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] data, input exp_t e);
    int dc;
    exp_t x;
    x = e;
    send_byte(SYNC_BYTE, dc);
    send_byte(cmd, dc);
    send_byte(data, dc);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ data, dc);
`endif
    x.at = dc + 2;
    sbq.push_back(x);
  endtask

  task automatic wait_sb(input int maxc);
    for (int i = 0; i < maxc && sbq.size() != 0; i++) @(posedge CLK);
    @(posedge CLK); #1;
    chk("pending_pulses", sbq.size(), 0);
    sbq.delete();
    chk("busy_after_pkt", {31'd0, o_Busy}, 0);
  endtask

  function automatic exp_t mk(input logic is_err, input logic [3:0] p,
                              input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
    exp_t x;
    x.is_err = is_err; x.pat = p; x.r = r; x.g = g; x.b = b; x.at = 0;
    return x;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int dc, k;
    exp_t x;

    vecs[0]  = '{8'h01, 8'h07, 1'b0, 4'h7, 3'd0, 3'd0, 3'd0};
    vecs[1]  = '{8'h02, 8'h03, 1'b0, 4'h7, 3'd3, 3'd0, 3'd0};
    vecs[2]  = '{8'h03, 8'hFE, 1'b0, 4'h7, 3'd3, 3'd6, 3'd0};
    vecs[3]  = '{8'h04, 8'h09, 1'b0, 4'h7, 3'd3, 3'd6, 3'd1};
    vecs[4]  = '{8'h05, 8'hB6, 1'b0, 4'h7, 3'd5, 3'd5, 3'd4};
    vecs[5]  = '{8'h09, 8'h00, 1'b1, 4'h7, 3'd5, 3'd5, 3'd4};
    vecs[6]  = '{8'h01, 8'hFA, 1'b0, 4'hA, 3'd5, 3'd5, 3'd4};
    vecs[7]  = '{8'hA5, 8'h00, 1'b1, 4'hA, 3'd5, 3'd5, 3'd4};
    vecs[8]  = '{8'h05, 8'hFF, 1'b0, 4'hA, 3'd7, 3'd7, 3'd6};
    vecs[9]  = '{8'h00, 8'h12, 1'b1, 4'hA, 3'd7, 3'd7, 3'd6};
    vecs[10] = '{8'h02, 8'hF8, 1'b0, 4'hA, 3'd0, 3'd7, 3'd6};

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pattern", {28'd0, o_Pattern}, 0);
    chk("rst_red", {29'd0, o_Red}, 0);
    chk("rst_green", {29'd0, o_Green}, 0);
    chk("rst_blue", {29'd0, o_Blue}, 0);
    chk("rst_valid", {31'd0, o_Cmd_Valid}, 0);
    chk("rst_err", {31'd0, o_Err}, 0);
    chk("rst_busy", {31'd0, o_Busy}, 0);
    RST_N = 1'b1;

    // Table-driven packets
    for (int i = 0; i < 11; i++) begin
      send_pkt(vecs[i].cmd, vecs[i].data,
               mk(vecs[i].is_err, vecs[i].pat, vecs[i].r, vecs[i].g, vecs[i].b));
      wait_sb(10);
    end

    // Stray byte in IDLE is ignored, then unknown command rejected
    send_byte(8'h3C, dc);
    chk("stray_busy", {31'd0, o_Busy}, 0);
    send_byte(SYNC_BYTE, dc);
    chk("sync_busy", {31'd0, o_Busy}, 1);
    send_byte(8'h09, dc);
    send_byte(8'h00, dc);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h09, dc);
`endif
    x = mk(1'b1, 4'hA, 3'd0, 3'd7, 3'd6); x.at = dc + 2; sbq.push_back(x);
    wait_sb(10);

    // A byte held valid into APPLY must be ignored
    send_byte(SYNC_BYTE, dc);
    send_byte(CMD_BLUE, dc);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h02, dc);
    @(posedge CLK); #1;
    dc = cyc; i_RX_DV = 1'b1; i_RX_Byte = 8'h06;
`else
    @(posedge CLK); #1;
    dc = cyc; i_RX_DV = 1'b1; i_RX_Byte = 8'h02;
`endif
    @(posedge CLK); #1;
    i_RX_Byte = SYNC_BYTE;
    @(posedge CLK); #1;
    i_RX_DV = 1'b0;
    x = mk(1'b0, 4'hA, 3'd0, 3'd7, 3'd2); x.at = dc + 2; sbq.push_back(x);
    chk("apply_dv_ignored_busy", {31'd0, o_Busy}, 0);
    wait_sb(10);

    // Inter-byte timeout after A5,02
    send_byte(SYNC_BYTE, dc);
    send_byte(CMD_RED, dc);
    x = mk(1'b1, 4'hA, 3'd0, 3'd7, 3'd2); x.at = dc + TO + 1; sbq.push_back(x);
    wait_sb(TO + 20);
    send_pkt(CMD_RED, 8'h03, mk(1'b0, 4'hA, 3'd3, 3'd7, 3'd2));
    wait_sb(10);

    // Byte arriving on the exact expiry cycle wins over the timeout
    send_byte(SYNC_BYTE, k);
    repeat (TO - 2) @(posedge CLK);
    send_byte(CMD_PATTERN, dc);
    chk("late_byte_drive_cycle", dc, k + TO);
    send_byte(8'h05, dc);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h04, dc);
`endif
    x = mk(1'b0, 4'h5, 3'd3, 3'd7, 3'd2); x.at = dc + 2; sbq.push_back(x);
    wait_sb(10);

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum is rejected with colours unchanged
    send_byte(SYNC_BYTE, dc);
    send_byte(CMD_RGB, dc);
    send_byte(8'hB6, dc);
    send_byte(8'h00, dc);
    x = mk(1'b1, 4'h5, 3'd3, 3'd7, 3'd2); x.at = dc + 2; sbq.push_back(x);
    wait_sb(10);
`endif

    // Asynchronous reset mid-packet
    send_byte(SYNC_BYTE, dc);
    send_byte(CMD_RGB, dc);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hB6, dc);
`endif
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    chk("arst_pattern", {28'd0, o_Pattern}, 0);
    chk("arst_red", {29'd0, o_Red}, 0);
    chk("arst_green", {29'd0, o_Green}, 0);
    chk("arst_blue", {29'd0, o_Blue}, 0);
    chk("arst_busy", {31'd0, o_Busy}, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    send_pkt(CMD_GREEN, 8'h05, mk(1'b0, 4'h0, 3'd0, 3'd5, 3'd0));
    wait_sb(10);

    repeat (5) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
